// File: rtl/led_scan_pkg.sv
// Shared constants and types for the LED frame scanner.
// LED_SCAN_BLANK_EN adds the BLANK state to the scanner state enum.
package led_scan_pkg;

    localparam int NUM_COLS = 7;
    localparam int NUM_ROWS = 5;

    typedef logic [2:0] col_idx_t;

`ifdef LED_SCAN_BLANK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1
    } scan_state_e;
`endif

    localparam col_idx_t LAST_COL = col_idx_t'(NUM_COLS - 1);

endpackage

// File: rtl/led_dwell_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero, so a
// load of N-1 yields exactly N cycles before done_o is seen.
module led_dwell_timer
    import led_scan_pkg::*;
#(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/led_frame_scanner.sv
// Triple-buffered 7x5 LED matrix column scanner with tear-free swap at col 0.
// Define LED_SCAN_BLANK_EN to insert BLANK_CYC dark cycles between columns.
module led_frame_scanner
    import led_scan_pkg::*;
#(
    parameter int DWELL     = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pt_valid,
    input  logic [6:0] pt_x,
    input  logic [4:0] pt_y,
    input  logic       frame_end,
    output logic [6:0] col_sel,
    output logic [4:0] row_data,
    output logic       frame_sync,
    output logic       frame_overrun
);

    localparam int MAX_LEN = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int TMR_W   = $clog2(MAX_LEN + 1);
    localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL - 1);
`ifdef LED_SCAN_BLANK_EN
    localparam logic [TMR_W-1:0] BLANK_LD = TMR_W'(BLANK_CYC - 1);
`endif
    localparam logic [NUM_COLS-1:0] COL0_SEL = {1'b1, {(NUM_COLS-1){1'b0}}};

    scan_state_e state_q, state_d;
    col_idx_t    col_q, col_d;
    col_idx_t    enter_col;
    logic        enter;
    logic        swap;

    logic [NUM_COLS-1:0] col_sel_q, col_sel_d;
    logic [NUM_ROWS-1:0] row_data_q, row_data_d;
    logic                frame_sync_q, frame_sync_d;
    logic                frame_overrun_q, frame_overrun_d;
    logic                pend_q, pend_d;

    logic [NUM_ROWS-1:0] wbuf_q [NUM_COLS];
    logic [NUM_ROWS-1:0] wbuf_d [NUM_COLS];
    logic [NUM_ROWS-1:0] wbuf_pt[NUM_COLS];
    logic [NUM_ROWS-1:0] pbuf_q [NUM_COLS];
    logic [NUM_ROWS-1:0] pbuf_d [NUM_COLS];
    logic [NUM_ROWS-1:0] dbuf_q [NUM_COLS];
    logic [NUM_ROWS-1:0] dbuf_d [NUM_COLS];

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    led_dwell_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_SCAN;
            ST_SCAN: begin
                if (tmr_done) begin
`ifdef LED_SCAN_BLANK_EN
                    state_d = ST_BLANK;
`else
                    state_d = ST_SCAN;
`endif
                end
            end
`ifdef LED_SCAN_BLANK_EN
            ST_BLANK: if (tmr_done) state_d = ST_SCAN;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/timer control; "enter" marks the first cycle of a column's dwell.
    always_comb begin
        tmr_load   = 1'b0;
        tmr_val    = DWELL_LD;
        enter      = 1'b0;
        enter_col  = col_q;
        col_d      = col_q;
        col_sel_d  = col_sel_q;
        row_data_d = row_data_q;
        case (state_q)
            ST_IDLE: begin
                enter     = 1'b1;
                enter_col = '0;
            end
            ST_SCAN: begin
                if (tmr_done) begin
`ifdef LED_SCAN_BLANK_EN
                    tmr_load   = 1'b1;
                    tmr_val    = BLANK_LD;
                    col_sel_d  = '0;
                    row_data_d = '0;
`else
                    enter     = 1'b1;
                    enter_col = (col_q == LAST_COL) ? '0 : col_q + col_idx_t'(1);
`endif
                end
            end
`ifdef LED_SCAN_BLANK_EN
            ST_BLANK: begin
                if (tmr_done) begin
                    enter     = 1'b1;
                    enter_col = (col_q == LAST_COL) ? '0 : col_q + col_idx_t'(1);
                end
            end
`endif
            default: ;
        endcase

        swap         = enter && (enter_col == '0) && pend_q;
        frame_sync_d = enter && (enter_col == '0);
        if (enter) begin
            tmr_load   = 1'b1;
            tmr_val    = DWELL_LD;
            col_d      = enter_col;
            col_sel_d  = COL0_SEL >> enter_col;
            row_data_d = swap ? pbuf_q[0] : dbuf_q[enter_col];
        end
    end

    // A commit landing on the swap cycle refills pbuf after the swap reads it.
    always_comb begin
        for (int i = 0; i < NUM_COLS; i++) begin
            wbuf_pt[i] = wbuf_q[i] | ((pt_valid && pt_x[NUM_COLS-1-i]) ? pt_y : '0);
            wbuf_d[i]  = frame_end ? '0 : wbuf_pt[i];
            pbuf_d[i]  = frame_end ? wbuf_pt[i] : pbuf_q[i];
            dbuf_d[i]  = swap ? pbuf_q[i] : dbuf_q[i];
        end
        pend_d          = frame_end | (pend_q & ~swap);
        frame_overrun_d = frame_end & pend_q & ~swap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q           <= '0;
            col_sel_q       <= '0;
            row_data_q      <= '0;
            frame_sync_q    <= 1'b0;
            frame_overrun_q <= 1'b0;
            pend_q          <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) begin
                wbuf_q[i] <= '0;
                pbuf_q[i] <= '0;
                dbuf_q[i] <= '0;
            end
        end else begin
            col_q           <= col_d;
            col_sel_q       <= col_sel_d;
            row_data_q      <= row_data_d;
            frame_sync_q    <= frame_sync_d;
            frame_overrun_q <= frame_overrun_d;
            pend_q          <= pend_d;
            for (int i = 0; i < NUM_COLS; i++) begin
                wbuf_q[i] <= wbuf_d[i];
                pbuf_q[i] <= pbuf_d[i];
                dbuf_q[i] <= dbuf_d[i];
            end
        end
    end

    assign col_sel       = col_sel_q;
    assign row_data      = row_data_q;
    assign frame_sync    = frame_sync_q;
    assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_led_frame_scanner.sv
// Randomized bench for led_frame_scanner against a frame-position reference model.
`timescale 1ns/1ps
module tb_led_frame_scanner;

    localparam int DWELL     = 4;
    localparam int BLANK_CYC = 2;
`ifdef LED_SCAN_BLANK_EN
    localparam int SLOT = DWELL + BLANK_CYC;
`else
    localparam int SLOT = DWELL;
`endif
    localparam int PER = 7 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pt_valid = 1'b0;
    logic [6:0] pt_x = '0;
    logic [4:0] pt_y = '0;
    logic       frame_end = 1'b0;
    logic [6:0] col_sel;
    logic [4:0] row_data;
    logic       frame_sync;
    logic       frame_overrun;

    always #5 clk = ~clk;

    led_frame_scanner #(.DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pt_valid      (pt_valid),
        .pt_x          (pt_x),
        .pt_y          (pt_y),
        .frame_end     (frame_end),
        .col_sel       (col_sel),
        .row_data      (row_data),
        .frame_sync    (frame_sync),
        .frame_overrun (frame_overrun)
    );

    int n_vec = 0;
    int n_err = 0;
    int fs_cnt = 0;
    int ov_cnt = 0;

    // Reference state: three frame buffers, pending flag, edges since release.
    logic [4:0] m_w [7];
    logic [4:0] m_p [7];
    logic [4:0] m_d [7];
    bit         m_pend;
    bit         m_ov;
    int         m_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        m_pend = 1'b0;
        m_ov = 1'b0;
        for (int i = 0; i < 7; i++) begin
            m_w[i] = '0;
            m_p[i] = '0;
            m_d[i] = '0;
        end
    endtask

    task automatic model_step();
        logic [4:0] wpt [7];
        int p;
        bit sw;
        m_t++;
        p = (m_t - 1) % PER;
        sw = (p == 0) && m_pend;
        for (int i = 0; i < 7; i++)
            wpt[i] = m_w[i] | ((pt_valid && pt_x[6-i]) ? pt_y : 5'd0);
        m_ov = frame_end && m_pend && !sw;
        if (sw)
            for (int i = 0; i < 7; i++) m_d[i] = m_p[i];
        for (int i = 0; i < 7; i++) begin
            if (frame_end) begin
                m_p[i] = wpt[i];
                m_w[i] = '0;
            end else begin
                m_w[i] = wpt[i];
            end
        end
        if (frame_end) m_pend = 1'b1;
        else if (sw)   m_pend = 1'b0;
    endtask

    task automatic check_outputs();
        logic [6:0] e_cs;
        logic [4:0] e_rd;
        bit e_fs;
        int p, c;
        e_cs = '0;
        e_rd = '0;
        e_fs = 1'b0;
        if (m_t > 0) begin
            p = (m_t - 1) % PER;
            c = p / SLOT;
            if ((p % SLOT) < DWELL) begin
                e_cs = 7'h40 >> c;
                e_rd = m_d[c];
            end
            e_fs = (p == 0);
        end
        check("col_sel", 32'(col_sel), 32'(e_cs));
        check("row_data", 32'(row_data), 32'(e_rd));
        check("frame_sync", 32'(frame_sync), 32'(e_fs));
        check("frame_overrun", 32'(frame_overrun), 32'(m_ov));
        if (frame_sync) fs_cnt++;
        if (frame_overrun) ov_cnt++;
    endtask

    task automatic cycle(input bit v, input logic [6:0] x, input logic [4:0] y, input bit fe);
        pt_valid = v;
        pt_x = x;
        pt_y = y;
        frame_end = fe;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 7'd0, 5'd0, 1'b0);
    endtask

    // Idle until the next edge lands on frame position ph.
    task automatic wait_phase(input int ph, input string tag);
        int g;
        g = 0;
        while ((m_t % PER) != ph && g < PER + 2) begin
            idle(1);
            g++;
        end
        if ((m_t % PER) != ph) check(tag, 32'(m_t % PER), 32'(ph));
    endtask

    initial begin
        bit found;
        int g;
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_outputs();
        idle(2);

        // Blank scan after release
        rst_n = 1'b1;
        fs_cnt = 0;
        idle(1);
        check("first_col", 32'(col_sel), 32'h40);
        idle(2 * PER - 1);
        check("idle_sync_count", 32'(fs_cnt), 32'd2);

        // Single point commit, visible only on col 3 after the wrap
        cycle(1'b1, 7'b0001000, 5'b00100, 1'b0);
        cycle(1'b0, 7'd0, 5'd0, 1'b1);
        idle(PER);
        found = 1'b0;
        g = 0;
        while (!found && g < PER) begin
            idle(1);
            g++;
            if (col_sel == 7'b0001000) begin
                found = 1'b1;
                check("col3_row", 32'(row_data), 32'h04);
            end
        end
        if (!found) check("col3_seen", 32'(found), 32'd1);

        // Two commits 3 cycles apart mid-frame
        wait_phase(8, "align_overrun");
        ov_cnt = 0;
        cycle(1'b1, 7'b1100000, 5'b00001, 1'b1);
        idle(2);
        cycle(1'b1, 7'b0000011, 5'b10000, 1'b1);
        idle(4);
        check("overrun_count", 32'(ov_cnt), 32'd1);
        idle(PER + 2);

        // Commit landing exactly on the wrap swap
        cycle(1'b1, 7'b0100000, 5'b00011, 1'b1);
        wait_phase(0, "align_wrap");
        ov_cnt = 0;
        cycle(1'b1, 7'b0000010, 5'b11000, 1'b1);
        idle(3);
        check("wrap_no_overrun", 32'(ov_cnt), 32'd0);
        idle(2 * PER);

        // Point and commit in the same cycle, then an empty commit
        cycle(1'b1, 7'b1000001, 5'b10001, 1'b1);
        idle(5);
        cycle(1'b0, 7'd0, 5'd0, 1'b1);
        idle(2 * PER);

        // Random traffic
        for (int k = 0; k < 1500; k++)
            cycle($urandom_range(0, 9) < 3, 7'($urandom), 5'($urandom), $urandom_range(0, 99) < 3);

        // Reset pulse during column 3
        cycle(1'b1, 7'h7f, 5'h1f, 1'b1);
        g = 0;
        while (!(m_t > 0 && (((m_t - 1) % PER) / SLOT) == 3 && (((m_t - 1) % PER) % SLOT) == 1)
               && g < 2 * PER + 2) begin
            idle(1);
            g++;
        end
        check("col3_before_rst", 32'(col_sel), 32'h08);
        rst_n = 1'b0;
        #1;
        check("rst_async_col_sel", 32'(col_sel), 32'd0);
        check("rst_async_row_data", 32'(row_data), 32'd0);
        check("rst_async_frame_sync", 32'(frame_sync), 32'd0);
        check("rst_async_overrun", 32'(frame_overrun), 32'd0);
        model_reset();
        idle(3);
        rst_n = 1'b1;
        idle(1);
        check("restart_col", 32'(col_sel), 32'h40);
        check("restart_row", 32'(row_data), 32'd0);
        for (int k = 0; k < PER; k++)
            cycle($urandom_range(0, 1) == 1, 7'($urandom), 5'($urandom), 1'b0);
        for (int k = 0; k < 500; k++)
            cycle($urandom_range(0, 9) < 3, 7'($urandom), 5'($urandom), $urandom_range(0, 99) < 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_frame_scanner.md
LED_FRAME_SCANNER -- requirements
Module: led_frame_scanner

Interface
REQ-001 Parameter DWELL, default 50000, clock cycles each column is driven (legal range 1..2^20-1).
REQ-002 Parameter BLANK_CYC, default 500, blanking cycles between columns when LED_SCAN_BLANK_EN is defined (legal range 1..2^16-1).
REQ-003 Port clk, input, 1, sole clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port pt_valid, input, 1, point-write strobe from the snake game stage.
REQ-006 Port pt_x, input, 7, column pattern; bit 6 = leftmost column (col 0), bit 0 = col 6.
REQ-007 Port pt_y, input, 5, row pattern ORed into every column selected by pt_x.
REQ-008 Port frame_end, input, 1, single-cycle pulse that commits the accumulated frame.
REQ-009 Port col_sel, output, 7, registered one-hot column drive, active high.
REQ-010 Port row_data, output, 5, registered row drive for the active column, active high.
REQ-011 Port frame_sync, output, 1, one-cycle pulse in the cycle col 0 becomes active.
REQ-012 Port frame_overrun, output, 1, one-cycle pulse when a committed frame is replaced before display.

Function
REQ-013 Three 7x5 buffers SHALL exist: write (wbuf), pending (pbuf), display (dbuf), plus flag pend.
REQ-014 On pt_valid, every column i with pt_x[6-i]=1 SHALL get wbuf[i] |= pt_y; pt_x=0 is a no-op; multi-hot pt_x writes all selected columns.
REQ-015 On frame_end: pbuf <= wbuf including any same-cycle point, wbuf <= 0, pend <= 1.
REQ-016 frame_end while pend=1 SHALL overwrite pbuf (latest wins) and pulse frame_overrun the next cycle.
REQ-017 Scanner FSM states: IDLE, SCAN, BLANK; IDLE is left on the first edge after reset release, going to SCAN with col 0.
REQ-018 In SCAN with column c: col_sel has only bit 6-c set, row_data = dbuf[c], held for exactly DWELL cycles.
REQ-019 After SCAN ends: next state is BLANK if the blanking feature is compiled in, else SCAN with c+1; c wraps 6->0.
REQ-020 On entering col 0 with pend=1: dbuf <= pbuf and pend <= 0 in that cycle; row_data for col 0 SHALL already show the new frame (tear-free swap only at wrap).
REQ-021 frame_end coinciding with the wrap swap SHALL load the new frame into pbuf with pend=1 after the swap has consumed the old pbuf; no overrun pulse.
REQ-022 frame_sync SHALL pulse in every cycle in which the col 0 SCAN interval starts, including the first after reset.
REQ-023 Frame period SHALL be 7*DWELL cycles, or 7*(DWELL+BLANK_CYC) with blanking.

Reset
REQ-024 rst_n low SHALL immediately clear col_sel, row_data, frame_sync, frame_overrun, all buffers, pend, the counters, and force IDLE.
REQ-025 Reset asserted mid-column or mid-blank SHALL abort the scan with no further output activity; after release the scan restarts at col 0 with a blank frame.

Configuration
REQ-026 Macro LED_SCAN_BLANK_EN defined: BLANK state present, col_sel=0 and row_data=0 for BLANK_CYC cycles between consecutive columns (ghosting suppression).
REQ-027 LED_SCAN_BLANK_EN undefined: BLANK state and its counter absent, columns back-to-back, BLANK_CYC ignored.

Structure
REQ-028 Package led_scan_pkg SHALL hold NUM_COLS=7, NUM_ROWS=5, the scanner state enum and the column-index type.
REQ-029 Sub-module led_dwell_timer (loadable down-counter with done pulse) SHALL time both SCAN and BLANK intervals.

Verification (DWELL=4, BLANK_CYC=2)
REQ-030 Reset release, no points -> col_sel steps 1000000,0100000,... every 4 cycles, row_data=0, frame_sync every 28 cycles (42 with blanking).
REQ-031 pt_x=0001000, pt_y=00100, then frame_end -> from the next col 0 onward, row_data=00100 only while col_sel=0001000.
REQ-032 Two frame_end pulses 3 cycles apart mid-frame -> one frame_overrun pulse; the second frame is displayed at the wrap.
REQ-033 pt_valid and frame_end in the same cycle -> that point appears in the committed frame, and wbuf is empty afterwards.
REQ-034 rst_n pulsed low during col 3 -> outputs 0 immediately; after release the scan restarts at col 0 with blank data.
REQ-035 LED_SCAN_BLANK_EN defined -> exactly 2 cycles of col_sel=0 between every pair of columns, including col 6->col 0.
